uart_rx: RTL and testbench

UART receiver, the receive-side counterpart of the 8N1 transmitter in this UART block. It takes the asynchronous serial line `rx`, synchronises it into `clk`, finds and validates the start bit, and samples 8 data bits LSB-first at bit centres. It checks the stop bit and then presents the byte with a one-cycle `done_rx` strobe, or flags a framing error. It sits between the board RX pin and the user logic and shares baud parameters with the transmitter.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_sync.sv | 41 ++++
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART block (receiver and transmitter).
//   - Default system clock and baud rate.
//   - Helpers that derive clocks-per-bit and clocks-to-bit-centre.
//   - Receiver FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int SYS_CLK_DEF = 50_000_000;
    localparam int BPS_DEF     = 9600;

    // Clocks per bit period; integer division truncates, so the real baud
    // rate is slightly faster than requested (well inside the margin).
    function automatic int bit_clocks(input int sys_clk, input int bps);
        return sys_clk / bps;
    endfunction

    // Clocks from the start edge to the start-bit centre.
    function automatic int half_clocks(input int delay);
        return delay / 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// ---------------------------------------------------------------------------
// uart_sync
// Brings the asynchronous serial line into the clk domain with two flops.
// A third flop keeps one cycle of history so a falling edge can be detected.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   rx     in   raw serial line (idle high)
//   rx_s2  out  synchronised line level
//   fall   out  high for one cycle after a high-to-low transition
// ---------------------------------------------------------------------------
module uart_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s2,
    output logic fall
);

    logic rx_s1;
    logic rx_s3;

    // Synchroniser chain plus edge-history flop. Everything resets to the
    // idle level so that leaving reset on an idle line never looks like a
    // start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // Previous level high, current level low: a falling edge.
    assign fall = rx_s3 & ~rx_s2;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. Finds the start edge, confirms the start bit at its
// centre, samples 8 data bits LSB-first at bit centres, then checks the stop
// bit and either publishes the byte or flags a framing error.
// Parameters:
//   SYS_CLK  system clock in Hz
//   BPS      baud rate
//   DELAY    clocks per bit (derived)
//   HALF     clocks to start-bit centre (derived)
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous
//   data_rx    out  last correctly framed byte
//   done_rx    out  one-cycle strobe, data_rx updated
//   err_frame  out  one-cycle strobe, stop bit was low, byte discarded
//   busy_rx    out  high whenever a frame is being received
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYS_CLK = SYS_CLK_DEF,
    parameter int BPS     = BPS_DEF,
    parameter int DELAY   = bit_clocks(SYS_CLK, BPS),
    parameter int HALF    = half_clocks(DELAY)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_rx,
    output logic       done_rx,
    output logic       err_frame,
    output logic       busy_rx
);

    localparam logic [15:0] BIT_LAST  = 16'(DELAY - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

    uart_state_t state;
    uart_state_t state_nxt;

    logic        rx_s2;
    logic        fall;
    logic [15:0] cnt_bps;
    logic [2:0]  cnt_bit;
    logic [7:0]  shreg;

    logic        bit_end;
    logic        half_end;
    logic        sample_bit;
    logic        frame_ok;
    logic        frame_bad;

    uart_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rx_s2 (rx_s2),
        .fall  (fall)
    );

    assign bit_end  = (cnt_bps == BIT_LAST);
    assign half_end = (cnt_bps == HALF_LAST);
    assign busy_rx  = (state != IDLE);

    // Next-state and sampling decisions. The start bit is re-checked at its
    // centre so that short glitches on the idle line are rejected silently.
    always_comb begin
        state_nxt  = state;
        sample_bit = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (fall) state_nxt = START;
            end
            START: begin
                if (half_end) state_nxt = rx_s2 ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end) begin
                    sample_bit = 1'b1;
                    if (cnt_bit == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    frame_ok  = rx_s2;
                    frame_bad = ~rx_s2;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Bit-period and bit-index counters. Both restart on every state change
    // so each state measures time from its own entry point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_bps <= '0;
            cnt_bit <= '0;
        end else if (state_nxt != state) begin
            cnt_bps <= '0;
            cnt_bit <= '0;
        end else begin
            if (state == IDLE || bit_end) cnt_bps <= '0;
            else                          cnt_bps <= cnt_bps + 16'd1;
            if (sample_bit) cnt_bit <= cnt_bit + 3'd1;
        end
    end

    // LSB arrives first, so shifting in from the top leaves bit 0 at the
    // bottom after eight samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          shreg <= '0;
        else if (sample_bit) shreg <= {rx_s2, shreg[7:1]};
    end

    // Registered outputs. A bad stop bit discards the byte and leaves the
    // previously published value in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_rx   <= 8'h00;
            done_rx   <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            done_rx   <= frame_ok;
            err_frame <= frame_bad;
            if (frame_ok) data_rx <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Two receivers: a fast one (1 Mbaud at
// 50 MHz, 50 clocks/bit) for the functional scenarios and a 115200 baud one
// for the baud-offset scenario. Stimulus pushes expected strobes into a
// per-receiver queue; a monitor per receiver pops and compares whenever a
// strobe appears.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DELAY_M = 50;    // 50_000_000 / 1_000_000
    localparam int HALF_M  = 25;
    localparam int DELAY_F = 434;   // 50_000_000 / 115_200
    localparam int HALF_F  = 217;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        longint     when;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_m = 1'b1;
    logic       rx_f = 1'b1;
    logic [7:0] data_m, data_f;
    logic       done_m, done_f, err_m, err_f, busy_m, busy_f;

    longint     cyc = 0;
    int         total = 0;
    int         bad = 0;
    exp_t       exp_m[$];
    exp_t       exp_f[$];
    logic [7:0] good_m = 8'h00;
    logic [7:0] good_f = 8'h00;
    bit         prev_m = 1'b0;
    bit         prev_f = 1'b0;

    uart_rx #(.SYS_CLK(50_000_000), .BPS(1_000_000)) dut_m (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx_m),
        .data_rx   (data_m),
        .done_rx   (done_m),
        .err_frame (err_m),
        .busy_rx   (busy_m)
    );

    uart_rx #(.SYS_CLK(50_000_000), .BPS(115_200)) dut_f (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx_f),
        .data_rx   (data_f),
        .done_rx   (done_f),
        .err_frame (err_f),
        .busy_rx   (busy_f)
    );

    // 100 MHz-style free-running clock and a cycle counter of rising edges.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    task automatic driveLine(input bit fast, input logic v);
        if (fast) rx_f = v;
        else      rx_m = v;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends one 8N1 frame starting now (caller is just after a negedge) and
    // queues the strobe the receiver must produce. The line is left at the
    // stop-bit level.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_val,
                                 input int bit_clks, input bit fast);
        exp_t e;
        e.is_err = !stop_val;
        e.when   = cyc + 3 + (fast ? (HALF_F + 9 * DELAY_F) : (HALF_M + 9 * DELAY_M));
        if (fast) begin
            if (stop_val) good_f = b;
            e.data = good_f;
            exp_f.push_back(e);
        end else begin
            if (stop_val) good_m = b;
            e.data = good_m;
            exp_m.push_back(e);
        end
        driveLine(fast, 1'b0);
        idleCycles(bit_clks);
        for (int i = 0; i < 8; i++) begin
            driveLine(fast, b[i]);
            idleCycles(bit_clks);
        end
        driveLine(fast, stop_val);
        idleCycles(bit_clks);
    endtask

    // Monitor for the 1 Mbaud receiver.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_m = 1'b0;
        end else begin
            if (done_m || err_m) begin
                checkOutput("m_exclusive", done_m & err_m, 0);
                checkOutput("m_no_consecutive", prev_m, 0);
                checkOutput("m_strobe_expected", exp_m.size() != 0, 1);
                if (exp_m.size() != 0) begin
                    e = exp_m.pop_front();
                    checkOutput("m_err_frame", err_m, e.is_err);
                    checkOutput("m_data_rx", data_m, e.data);
                    checkOutput("m_strobe_cycle", cyc, e.when);
                end
            end
            prev_m = done_m | err_m;
        end
    end

    // Monitor for the 115200 baud receiver.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_f = 1'b0;
        end else begin
            if (done_f || err_f) begin
                checkOutput("f_exclusive", done_f & err_f, 0);
                checkOutput("f_no_consecutive", prev_f, 0);
                checkOutput("f_strobe_expected", exp_f.size() != 0, 1);
                if (exp_f.size() != 0) begin
                    e = exp_f.pop_front();
                    checkOutput("f_err_frame", err_f, e.is_err);
                    checkOutput("f_data_rx", data_f, e.data);
                    checkOutput("f_strobe_cycle", cyc, e.when);
                end
            end
            prev_f = done_f | err_f;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        repeat (100_000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int base;
        logic [7:0] part;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("rst_data_rx", data_m, 8'h00);
        checkOutput("rst_done_rx", done_m, 0);
        checkOutput("rst_err_frame", err_m, 0);
        checkOutput("rst_busy_rx", busy_m, 0);
        rst_n = 1'b1;
        idleCycles(10);

        // Single frame, then two back-to-back frames.
        applyStimulus(8'h55, 1'b1, DELAY_M, 1'b0);
        idleCycles(20);
        applyStimulus(8'hA3, 1'b1, DELAY_M, 1'b0);
        applyStimulus(8'h0F, 1'b1, DELAY_M, 1'b0);
        idleCycles(20);

        // Low glitch shorter than half a bit: START entered two cycles after
        // the first capture, abandoned at the start-bit centre.
        base = int'(cyc);
        rx_m = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 20) rx_m = 1'b1;
            if (i == 2)  checkOutput("glitch_busy_before", busy_m, 0);
            if (i == 3)  checkOutput("glitch_busy_rise", busy_m, 1);
            if (i == 27) checkOutput("glitch_busy_held", busy_m, 1);
            if (i == 28) checkOutput("glitch_busy_fall", busy_m, 0);
        end
        checkOutput("glitch_cycles", int'(cyc) - base, 32);
        idleCycles(20);

        // Bad stop bit, line held low (break), then a good frame.
        applyStimulus(8'h3C, 1'b0, DELAY_M, 1'b0);
        checkOutput("err_keeps_data", data_m, 8'h0F);
        idleCycles(3 * DELAY_M - DELAY_M);
        checkOutput("break_busy", busy_m, 0);
        rx_m = 1'b1;
        idleCycles(DELAY_M);
        applyStimulus(8'h81, 1'b1, DELAY_M, 1'b0);
        idleCycles(20);

        // Reset in the middle of data bit 4.
        part = 8'h5A;
        rx_m = 1'b0;
        idleCycles(DELAY_M);
        for (int i = 0; i < 4; i++) begin
            rx_m = part[i];
            idleCycles(DELAY_M);
        end
        rx_m = part[4];
        idleCycles(DELAY_M / 2);
        checkOutput("midframe_busy", busy_m, 1);
        rst_n = 1'b0;
        rx_m  = 1'b1;
        good_m = 8'h00;
        good_f = 8'h00;
        idleCycles(3);
        checkOutput("midrst_data_rx", data_m, 8'h00);
        checkOutput("midrst_done_rx", done_m, 0);
        checkOutput("midrst_err_frame", err_m, 0);
        checkOutput("midrst_busy_rx", busy_m, 0);
        rst_n = 1'b1;
        idleCycles(60);
        applyStimulus(8'hE7, 1'b1, DELAY_M, 1'b0);
        idleCycles(20);

        // 115200 baud receiver with the sender 3% slow, then 3% fast.
        applyStimulus(8'h00, 1'b1, 447, 1'b1);
        applyStimulus(8'hFF, 1'b1, 421, 1'b1);
        idleCycles(20);

        // Every queued strobe must have been seen.
        waited = 0;
        while ((exp_m.size() != 0 || exp_f.size() != 0) && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain_main", exp_m.size(), 0);
        checkOutput("drain_fast", exp_f.size(), 0);
        checkOutput("final_data_main", data_m, 8'hE7);
        checkOutput("final_data_fast", data_f, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
